// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter and its fetch port, data port and memory.
// The arbiter connects through the slave modport; the surroundings use master.
interface mem_arbiter_if;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_done;

  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt;
  logic        d_done;

  logic [31:0] rdata;

  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_done, d_gnt, d_done, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_done, d_gnt, d_done, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between an instruction-fetch port and a load/store
// port onto one memory bus; data wins unless fetch has been passed over 4 times.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        write_q, write_d;
  logic        drop_q, drop_d;
  logic [2:0]  starve_q, starve_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic        grant_if, grant_d, may_grant;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rdata_d     = rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    grant_if    = 1'b0;
    grant_d     = 1'b0;

    // The completion cycle (raw done, even if suppressed) is never a grant cycle.
    may_grant = !rst && (state_q == ST_IDLE) && !if_done_q && !d_done_q;
    if (may_grant) begin
      if (bus.if_req && (starve_q == 3'd4 || !bus.d_req)) begin
        grant_if = 1'b1;
      end else if (bus.d_req) begin
        grant_d = 1'b1;
      end
    end

    if (!bus.if_req || grant_if) begin
      starve_d = 3'd0;
    end else if (grant_d && starve_q != 3'd4) begin
      starve_d = starve_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          owner_d     = OWN_IF;
          write_d     = 1'b0;
          drop_d      = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          state_d     = ST_REQ;
        end else if (grant_d) begin
          owner_d     = OWN_D;
          write_d     = bus.d_we;
          drop_d      = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_wmask_d = bus.d_wmask;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (write_q) begin
            d_done_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          if (owner_q == OWN_IF) begin
            if_done_d = 1'b1;
          end else begin
            d_done_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A taken branch orphans the fetch in flight; the bus side still completes.
    if (bus.if_flush && owner_q == OWN_IF && state_q != ST_IDLE) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      write_q     <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rdata_q     <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rdata_q     <= rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.d_gnt     = grant_d;
  assign bus.if_done   = if_done_q & ~drop_q & ~bus.if_flush;
  assign bus.d_done    = d_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;

endmodule
